// File: rtl/burst_rr_scheduler.sv
// Round-robin scheduler granting a shared burst resource to one of N requesters
// for a whole burst, re-arbitrating back-to-back at burst end.
//
// state | meaning
// IDLE  | no owner, grant all-zero, waiting for any req
// BUSY  | one-hot grant held until the latched burst length is consumed
module burst_rr_scheduler #(
  parameter int N     = 4,
  parameter int LEN_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               req,
  input  logic [N*LEN_W-1:0]         req_len,
  input  logic                       bus_ready,
  output logic [N-1:0]               grant,
  output logic [$clog2(N)-1:0]       owner,
  output logic                       busy,
  output logic                       beat_done,
  output logic                       last_beat
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [LEN_W-1:0] beats_left;
  logic [IDX_W-1:0] last_ptr;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W-1:0] load_len;
  logic [N-1:0]     win_onehot;

  // Search starts just after the last owner, so the previous owner ranks lowest.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_len = '0;
    for (int i = 0; i < N; i++) begin
      int pos;
      pos = (int'(last_ptr) + 1 + i) % N;
      for (int k = 0; k < N; k++) begin
        if (!found && pos == k && req[k]) begin
          found   = 1'b1;
          win     = IDX_W'(k);
          win_len = req_len[k*LEN_W +: LEN_W];
        end
      end
    end
  end

  assign load_len   = (win_len == '0) ? LEN_W'(1) : win_len;
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      beats_left <= '0;
      last_ptr   <= IDX_W'(N-1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= BUSY;
            grant      <= win_onehot;
            owner      <= win;
            busy       <= 1'b1;
            beats_left <= load_len;
            last_ptr   <= win;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            if (beats_left > LEN_W'(1)) begin
              beats_left <= beats_left - LEN_W'(1);
            end else if (found) begin
              grant      <= win_onehot;
              owner      <= win;
              beats_left <= load_len;
              last_ptr   <= win;
            end else begin
              state      <= IDLE;
              grant      <= '0;
              busy       <= 1'b0;
              beats_left <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign beat_done = busy & bus_ready;
  assign last_beat = busy && (beats_left == LEN_W'(1));

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed bench for burst_rr_scheduler: single burst, rotation, stall, wrap,
// edge-case lengths, request drop and reset mid-burst.
module tb_burst_rr_scheduler;

  localparam int N     = 4;
  localparam int LEN_W = 4;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*LEN_W-1:0] req_len;
  logic               bus_ready;
  logic [N-1:0]       grant;
  logic [1:0]         owner;
  logic               busy;
  logic               beat_done;
  logic               last_beat;

  int passed = 0;
  int total  = 0;

  burst_rr_scheduler #(.N(N), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .bus_ready (bus_ready),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .beat_done (beat_done),
    .last_beat (last_beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Owner is only meaningful while busy, so it is checked only when a grant is expected.
  task automatic chk(input string tag, input logic [N-1:0] e_grant, input logic [1:0] e_owner,
                     input logic e_bd, input logic e_lb);
    #1;
    cmp({tag, ".grant"}, 32'(grant), 32'(e_grant));
    cmp({tag, ".busy"}, 32'(busy), 32'(e_grant != '0));
    if (e_grant != '0) cmp({tag, ".owner"}, 32'(owner), 32'(e_owner));
    cmp({tag, ".beat_done"}, 32'(beat_done), 32'(e_bd));
    cmp({tag, ".last_beat"}, 32'(last_beat), 32'(e_lb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_len   = '0;
    bus_ready = 1'b1;
    tick();
    tick();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // single 3-beat burst
    req = 4'b0001; req_len = 16'h0003;
    tick(); req = '0; chk("s1.b1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("s1.b2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("s1.b3", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick(); chk("s1.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // rotation from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 4'b1111; req_len = 16'h1111;
    tick(); chk("s2.g0", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick(); chk("s2.g1", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); chk("s2.g2", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick(); chk("s2.g3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); chk("s2.g0b", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = '0;
    tick(); chk("s2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // stall: bus_ready 1,0,0,1 over a 2-beat burst
    req = 4'b0010; req_len = 16'h0020; bus_ready = 1'b1;
    tick(); req = '0; chk("s3.c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); bus_ready = 1'b0; chk("s3.c2", 4'b0010, 2'd1, 1'b0, 1'b1);
    tick(); chk("s3.c3", 4'b0010, 2'd1, 1'b0, 1'b1);
    tick(); bus_ready = 1'b1; chk("s3.c4", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); chk("s3.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // wrap: owner 3 finishes, requester 0 wins over 3, then 3 alone
    req = 4'b1000; req_len = 16'h1111;
    tick(); req = 4'b1001; chk("s4.own3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); req = 4'b1000; chk("s4.wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick(); req = '0; chk("s4.back3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); chk("s4.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // len=0 acts as a single beat
    req = 4'b0100; req_len = 16'h0000;
    tick(); req = '0; chk("s5.len0", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick(); chk("s5.len0.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // req dropped and req_len changed after grant: both ignored
    req = 4'b0010; req_len = 16'h0030;
    tick(); req = '0; req_len = 16'h00F0; chk("s5.drop.b1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("s5.drop.b2", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("s5.drop.b3", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); chk("s5.drop.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // reset in beat 2 of a 5-beat burst
    req = 4'b0001; req_len = 16'h0005;
    tick(); req = '0; chk("s6.b1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("s6.b2", 4'b0001, 2'd0, 1'b1, 1'b0);
    reset = 1'b1;
    tick(); chk("s6.abort", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; req = 4'b1111; req_len = 16'h1111;
    tick(); chk("s6.regrant", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = '0;
    tick(); chk("s6.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
